// File: rtl/mem_lsu.sv
// Multi-cycle load/store unit: one operation at a time over valid/ready, variable-latency
// data bus with ack/err/timeout, registered writeback result, LL/SC link and flush handling.
module mem_lsu #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned TIMEOUT    = 255,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_sdata,
    input  logic [4:0]        in_wd,
    input  logic              in_wreg,
    input  logic [31:0]       in_wdata,
    input  logic              flush,
    output logic              out_valid,
    output logic [4:0]        out_wd,
    output logic              out_wreg,
    output logic [31:0]       out_wdata,
    output logic [1:0]        out_exc,
    output logic [ADDR_W-1:0] out_badaddr,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_sel,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack,
    input  logic              bus_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8,
        OP_LL   = 4'd9,
        OP_SC   = 4'd10
    } op_e;

    localparam logic [1:0] EXC_NONE  = 2'd0;
    localparam logic [1:0] EXC_LOAD  = 2'd1;
    localparam logic [1:0] EXC_STORE = 2'd2;
    localparam logic [1:0] EXC_BUS   = 2'd3;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic [31:0]       bwdata_q, bwdata_d;
    logic [4:0]        res_wd_q, res_wd_d;
    logic              res_wreg_q, res_wreg_d;
    logic [31:0]       res_wdata_q, res_wdata_d;
    logic [1:0]        res_exc_q, res_exc_d;
    logic [ADDR_W-1:0] badaddr_q, badaddr_d;
    logic              link_valid_q, link_valid_d;
    logic [ADDR_W-3:0] link_addr_q, link_addr_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              flushed_q, flushed_d;

    op_e         op_in;
    logic        accept;
    logic        misaligned;
    logic        is_store_in;
    logic [1:0]  in_lane;
    logic        in_half_hi;
    logic [3:0]  sel_in;
    logic [31:0] bwdata_in;
    logic [1:0]  lane_q;
    logic        half_hi_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] tmo_next;
    logic        tmo_hit;
    logic        keep_result;
    logic        done;

    // Lane mapping: big-endian puts address offset 0 on the most significant byte lane.
    assign in_lane    = BIG_ENDIAN ? ~in_addr[1:0] : in_addr[1:0];
    assign in_half_hi = BIG_ENDIAN ? ~in_addr[1]   : in_addr[1];
    assign lane_q     = BIG_ENDIAN ? ~addr_q[1:0]  : addr_q[1:0];
    assign half_hi_q  = BIG_ENDIAN ? ~addr_q[1]    : addr_q[1];

    assign accept = in_valid && (state_q == S_IDLE) && !flush;

    always_comb begin
        op_in       = (in_op <= 4'd10) ? op_e'(in_op) : OP_NONE;
        misaligned  = 1'b0;
        is_store_in = 1'b0;
        sel_in      = '0;
        bwdata_in   = in_sdata;
        case (op_in)
            OP_LB, OP_LBU: sel_in = 4'b0001 << in_lane;
            OP_SB: begin
                sel_in      = 4'b0001 << in_lane;
                bwdata_in   = {4{in_sdata[7:0]}};
                is_store_in = 1'b1;
            end
            OP_LH, OP_LHU: begin
                sel_in     = in_half_hi ? 4'b1100 : 4'b0011;
                misaligned = in_addr[0];
            end
            OP_SH: begin
                sel_in      = in_half_hi ? 4'b1100 : 4'b0011;
                bwdata_in   = {2{in_sdata[15:0]}};
                misaligned  = in_addr[0];
                is_store_in = 1'b1;
            end
            OP_LW, OP_LL: begin
                sel_in     = 4'b1111;
                misaligned = |in_addr[1:0];
            end
            OP_SW, OP_SC: begin
                sel_in      = 4'b1111;
                misaligned  = |in_addr[1:0];
                is_store_in = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = bus_rdata[{lane_q, 3'b000} +: 8];
        ld_half = half_hi_q ? bus_rdata[31:16] : bus_rdata[15:0];
        case (op_q)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'd0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    assign tmo_next    = tmo_q + 32'd1;
    assign tmo_hit     = (TIMEOUT != 0) && (tmo_next == TIMEOUT);
    assign keep_result = !(flushed_q || flush);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        sel_d        = sel_q;
        we_d         = we_q;
        bwdata_d     = bwdata_q;
        res_wd_d     = res_wd_q;
        res_wreg_d   = res_wreg_q;
        res_wdata_d  = res_wdata_q;
        res_exc_d    = res_exc_q;
        badaddr_d    = badaddr_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        tmo_d        = tmo_q;
        flushed_d    = flushed_q;
        done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_d     = '0;
                flushed_d = 1'b0;
                if (accept) begin
                    op_d       = op_in;
                    addr_d     = in_addr;
                    sel_d      = sel_in;
                    we_d       = is_store_in;
                    bwdata_d   = bwdata_in;
                    res_wd_d   = in_wd;
                    res_wreg_d = in_wreg;
                    res_exc_d  = EXC_NONE;
                    if (op_in == OP_NONE) begin
                        res_wdata_d = in_wdata;
                        state_d     = S_RESP;
                    end else if (misaligned) begin
                        res_exc_d  = is_store_in ? EXC_STORE : EXC_LOAD;
                        badaddr_d  = in_addr;
                        res_wreg_d = 1'b0;
                        state_d    = S_RESP;
                    end else if (op_in == OP_SC &&
                                 !(link_valid_q && link_addr_q == in_addr[ADDR_W-1:2])) begin
                        res_wdata_d  = '0;
                        link_valid_d = 1'b0;
                        state_d      = S_RESP;
                    end else begin
                        state_d = S_BUS;
                    end
                end
            end

            S_BUS: begin
                tmo_d = tmo_next;
                if (flush) flushed_d = 1'b1;
                // err beats ack; an ack arriving on the timeout cycle still completes normally
                if (bus_err || (!bus_ack && tmo_hit)) begin
                    done       = 1'b1;
                    res_exc_d  = EXC_BUS;
                    badaddr_d  = addr_q;
                    res_wreg_d = 1'b0;
                    if (op_q == OP_SC) link_valid_d = 1'b0;
                end else if (bus_ack) begin
                    done = 1'b1;
                    if (!we_q) res_wdata_d = ld_data;
                    if (op_q == OP_SC) begin
                        res_wdata_d  = 32'd1;
                        link_valid_d = 1'b0;
                    end
                    if (op_q == OP_LL && keep_result) begin
                        link_valid_d = 1'b1;
                        link_addr_d  = addr_q[ADDR_W-1:2];
                    end
                    if ((op_q == OP_SB || op_q == OP_SH || op_q == OP_SW) &&
                        addr_q[ADDR_W-1:2] == link_addr_q)
                        link_valid_d = 1'b0;
                end
                // A flushed transfer finishes on the bus but retires silently
                if (done) state_d = keep_result ? S_RESP : S_IDLE;
            end

            S_RESP: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase

        if (flush) link_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_NONE;
            addr_q       <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            bwdata_q     <= '0;
            res_wd_q     <= '0;
            res_wreg_q   <= 1'b0;
            res_wdata_q  <= '0;
            res_exc_q    <= '0;
            badaddr_q    <= '0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            tmo_q        <= '0;
            flushed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            bwdata_q     <= bwdata_d;
            res_wd_q     <= res_wd_d;
            res_wreg_q   <= res_wreg_d;
            res_wdata_q  <= res_wdata_d;
            res_exc_q    <= res_exc_d;
            badaddr_q    <= badaddr_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            tmo_q        <= tmo_d;
            flushed_q    <= flushed_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_RESP) && !flush;
    assign out_wd      = res_wd_q;
    assign out_wreg    = res_wreg_q;
    assign out_wdata   = res_wdata_q;
    assign out_exc     = res_exc_q;
    assign out_badaddr = badaddr_q;
    assign bus_req     = (state_q == S_BUS);
    assign bus_we      = we_q;
    assign bus_addr    = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus_sel     = sel_q;
    assign bus_wdata   = bwdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: big-endian unit (TIMEOUT=8) checked through a result scoreboard,
// plus a little-endian unit for lane mirroring.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_wreg, flush;
    logic [3:0]  in_op;
    logic [31:0] in_addr, in_sdata, in_wdata;
    logic [4:0]  in_wd;
    logic        out_valid, out_wreg;
    logic [4:0]  out_wd;
    logic [31:0] out_wdata, out_badaddr;
    logic [1:0]  out_exc;
    logic        bus_req, bus_we, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_sel;

    logic        le_in_valid, le_in_ready, le_out_valid, le_out_wreg;
    logic [3:0]  le_in_op;
    logic [31:0] le_in_addr;
    logic [4:0]  le_out_wd;
    logic [31:0] le_out_wdata, le_out_badaddr;
    logic [1:0]  le_out_exc;
    logic        le_bus_req, le_bus_we, le_bus_ack;
    logic [31:0] le_bus_addr, le_bus_wdata, le_bus_rdata;
    logic [3:0]  le_bus_sel;

    mem_lsu #(.ADDR_W(32), .TIMEOUT(8), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
        .in_sdata(in_sdata), .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
        .flush(flush),
        .out_valid(out_valid), .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata),
        .out_exc(out_exc), .out_badaddr(out_badaddr),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    mem_lsu #(.ADDR_W(32), .TIMEOUT(255), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst(rst),
        .in_valid(le_in_valid), .in_ready(le_in_ready), .in_op(le_in_op), .in_addr(le_in_addr),
        .in_sdata(32'd0), .in_wd(5'd2), .in_wreg(1'b1), .in_wdata(32'd0),
        .flush(1'b0),
        .out_valid(le_out_valid), .out_wd(le_out_wd), .out_wreg(le_out_wreg),
        .out_wdata(le_out_wdata), .out_exc(le_out_exc), .out_badaddr(le_out_badaddr),
        .bus_req(le_bus_req), .bus_we(le_bus_we), .bus_addr(le_bus_addr), .bus_sel(le_bus_sel),
        .bus_wdata(le_bus_wdata), .bus_rdata(le_bus_rdata), .bus_ack(le_bus_ack), .bus_err(1'b0)
    );

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        chk_data;
        logic [1:0]  exc;
        logic [31:0] badaddr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic chk_data, input logic [1:0] exc, input logic [31:0] badaddr);
        exp_t e;
        e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.chk_data = chk_data;
        e.exc = exc; e.badaddr = badaddr;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_addr = addr; in_sdata = sdata;
        in_wd = wd; in_wreg = wreg; in_wdata = wdata;
        step();
        in_valid = 1'b0; in_op = 4'd0;
    endtask

    // Every result strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("out_valid_expected", 32'(out_valid), 32'(sb_q.size() != 0));
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("out_wd", 32'(out_wd), 32'(e.wd));
                chk("out_wreg", 32'(out_wreg), 32'(e.wreg));
                chk("out_exc", 32'(out_exc), 32'(e.exc));
                if (e.exc != 2'd0) chk("out_badaddr", out_badaddr, e.badaddr);
                else if (e.chk_data) chk("out_wdata", out_wdata, e.wdata);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_op = '0; in_addr = '0; in_sdata = '0;
        in_wd = '0; in_wreg = 1'b0; in_wdata = '0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        le_in_valid = 1'b0; le_in_op = '0; le_in_addr = '0; le_bus_ack = 1'b0; le_bus_rdata = '0;
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_sel", 32'(bus_sel), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_out_wdata", out_wdata, 32'd0);
        chk("rst_out_exc", 32'(out_exc), 32'd0);
        rst = 1'b0;
        step();

        // LB 0x1001, ack in third bus cycle
        push(5'd3, 1'b1, 32'hFFFF_FFF3, 1'b1, 2'd0, 32'd0);
        issue(4'd1, 32'h1001, 32'd0, 5'd3, 1'b1, 32'd0);
        chk("lb_bus_req", 32'(bus_req), 32'd1);
        chk("lb_bus_sel", 32'(bus_sel), 32'h4);
        chk("lb_bus_addr", bus_addr, 32'h1000);
        chk("lb_bus_we", 32'(bus_we), 32'd0);
        chk("lb_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("lb_bus_req_c2", 32'(bus_req), 32'd1);
        step();
        bus_ack = 1'b1; bus_rdata = 32'h12F3_5678;
        chk("lb_no_early_valid", 32'(out_valid), 32'd0);
        step();
        bus_ack = 1'b0; bus_rdata = '0;
        chk("lb_valid_after_ack", 32'(out_valid), 32'd1);
        chk("lb_req_dropped", 32'(bus_req), 32'd0);
        step();
        chk("lb_valid_one_cycle", 32'(out_valid), 32'd0);

        // LH 0x1002, ack in first bus cycle (minimum latency)
        push(5'd10, 1'b1, 32'hFFFF_8765, 1'b1, 2'd0, 32'd0);
        issue(4'd3, 32'h1002, 32'd0, 5'd10, 1'b1, 32'd0);
        chk("lh_bus_sel", 32'(bus_sel), 32'h3);
        bus_ack = 1'b1; bus_rdata = 32'h1234_8765;
        step();
        bus_ack = 1'b0;
        chk("lh_valid", 32'(out_valid), 32'd1);
        step();

        // NONE pass-through
        push(5'd9, 1'b1, 32'h55AA_00FF, 1'b1, 2'd0, 32'd0);
        issue(4'd0, 32'h0, 32'd0, 5'd9, 1'b1, 32'h55AA_00FF);
        chk("none_valid", 32'(out_valid), 32'd1);
        chk("none_bus_req", 32'(bus_req), 32'd0);
        step();

        // SH misaligned
        push(5'd4, 1'b0, 32'd0, 1'b0, 2'd2, 32'h3001);
        issue(4'd7, 32'h3001, 32'h1234, 5'd4, 1'b1, 32'd0);
        chk("sh_mis_bus_req", 32'(bus_req), 32'd0);
        chk("sh_mis_valid", 32'(out_valid), 32'd1);
        step();

        // LL then SC to the same word
        push(5'd5, 1'b1, 32'hCAFE_F00D, 1'b1, 2'd0, 32'd0);
        issue(4'd9, 32'h4000, 32'd0, 5'd5, 1'b1, 32'd0);
        chk("ll_bus_sel", 32'(bus_sel), 32'hF);
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        step();
        bus_ack = 1'b0;
        step();
        push(5'd6, 1'b1, 32'd1, 1'b1, 2'd0, 32'd0);
        issue(4'd10, 32'h4000, 32'hDEAD_BEEF, 5'd6, 1'b1, 32'd0);
        chk("sc_bus_req", 32'(bus_req), 32'd1);
        chk("sc_bus_we", 32'(bus_we), 32'd1);
        chk("sc_bus_sel", 32'(bus_sel), 32'hF);
        chk("sc_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
        chk("sc_bus_addr", bus_addr, 32'h4000);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        chk("sc_valid", 32'(out_valid), 32'd1);
        step();
        push(5'd7, 1'b1, 32'd0, 1'b1, 2'd0, 32'd0);
        issue(4'd10, 32'h4000, 32'hDEAD_BEEF, 5'd7, 1'b1, 32'd0);
        chk("sc2_no_bus", 32'(bus_req), 32'd0);
        chk("sc2_valid", 32'(out_valid), 32'd1);
        step();

        // LL, then SB into the linked word breaks the link
        push(5'd5, 1'b1, 32'h0102_0304, 1'b1, 2'd0, 32'd0);
        issue(4'd9, 32'h7000, 32'd0, 5'd5, 1'b1, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h0102_0304;
        step();
        bus_ack = 1'b0;
        step();
        push(5'd0, 1'b0, 32'd0, 1'b0, 2'd0, 32'd0);
        issue(4'd6, 32'h7002, 32'h0000_00AB, 5'd0, 1'b0, 32'd0);
        chk("sb_bus_sel", 32'(bus_sel), 32'h2);
        chk("sb_bus_wdata", bus_wdata, 32'hABAB_ABAB);
        chk("sb_bus_addr", bus_addr, 32'h7000);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        step();
        push(5'd11, 1'b1, 32'd0, 1'b1, 2'd0, 32'd0);
        issue(4'd10, 32'h7000, 32'h1, 5'd11, 1'b1, 32'd0);
        chk("sc_after_sb_no_bus", 32'(bus_req), 32'd0);
        step();

        // LL, then an idle flush breaks the link
        push(5'd5, 1'b1, 32'h0BAD_F00D, 1'b1, 2'd0, 32'd0);
        issue(4'd9, 32'h7400, 32'd0, 5'd5, 1'b1, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
        step();
        bus_ack = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        push(5'd13, 1'b1, 32'd0, 1'b1, 2'd0, 32'd0);
        issue(4'd10, 32'h7400, 32'h1, 5'd13, 1'b1, 32'd0);
        chk("sc_after_flush_no_bus", 32'(bus_req), 32'd0);
        step();

        // Bus error wins over a simultaneous ack
        push(5'd12, 1'b0, 32'd0, 1'b0, 2'd3, 32'h9002);
        issue(4'd4, 32'h9002, 32'd0, 5'd12, 1'b1, 32'd0);
        bus_err = 1'b1; bus_ack = 1'b1;
        step();
        bus_err = 1'b0; bus_ack = 1'b0;
        chk("err_valid", 32'(out_valid), 32'd1);
        step();

        // LW with no ack times out after 8 bus cycles
        push(5'd8, 1'b0, 32'd0, 1'b0, 2'd3, 32'h5000);
        issue(4'd5, 32'h5000, 32'd0, 5'd8, 1'b1, 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("tmo_req_held", 32'(bus_req), 32'd1);
            step();
        end
        chk("tmo_req_dropped", 32'(bus_req), 32'd0);
        chk("tmo_valid", 32'(out_valid), 32'd1);
        step();

        // Flush together with in_valid: not accepted
        in_valid = 1'b1; in_op = 4'd5; in_addr = 32'hA000; flush = 1'b1;
        step();
        in_valid = 1'b0; in_op = 4'd0; flush = 1'b0;
        chk("flush_accept_bus_req", 32'(bus_req), 32'd0);
        chk("flush_accept_in_ready", 32'(in_ready), 32'd1);
        step();

        // SW flushed in 2nd bus cycle, ack in 4th: transfer completes, no result
        issue(4'd8, 32'h6000, 32'h1122_3344, 5'd0, 1'b0, 32'd0);
        chk("swf_req_c1", 32'(bus_req), 32'd1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("swf_req_c3", 32'(bus_req), 32'd1);
        chk("swf_wdata", bus_wdata, 32'h1122_3344);
        step();
        bus_ack = 1'b1;
        chk("swf_req_c4", 32'(bus_req), 32'd1);
        step();
        bus_ack = 1'b0;
        chk("swf_req_dropped", 32'(bus_req), 32'd0);
        chk("swf_no_valid", 32'(out_valid), 32'd0);
        step();
        chk("swf_idle", 32'(in_ready), 32'd1);

        // Reset during a bus transfer
        issue(4'd5, 32'h8000, 32'd0, 5'd1, 1'b1, 32'd0);
        chk("rstbus_req", 32'(bus_req), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstbus_req_dropped", 32'(bus_req), 32'd0);
        chk("rstbus_in_ready", 32'(in_ready), 32'd1);
        chk("rstbus_no_valid", 32'(out_valid), 32'd0);
        step(); step();

        // Little-endian lanes: LHU 0x2002
        le_in_valid = 1'b1; le_in_op = 4'd4; le_in_addr = 32'h2002;
        step();
        le_in_valid = 1'b0;
        chk("le_lhu_sel", 32'(le_bus_sel), 32'hC);
        chk("le_lhu_addr", le_bus_addr, 32'h2000);
        le_bus_ack = 1'b1; le_bus_rdata = 32'h8001_1234;
        step();
        le_bus_ack = 1'b0;
        chk("le_lhu_valid", 32'(le_out_valid), 32'd1);
        chk("le_lhu_wdata", le_out_wdata, 32'h0000_8001);
        chk("le_lhu_exc", 32'(le_out_exc), 32'd0);
        step();

        // Little-endian LB 0x2001 takes byte lane 1, sign-extended
        le_in_valid = 1'b1; le_in_op = 4'd1; le_in_addr = 32'h2001;
        step();
        le_in_valid = 1'b0;
        chk("le_lb_sel", 32'(le_bus_sel), 32'h2);
        le_bus_ack = 1'b1; le_bus_rdata = 32'h8001_F234;
        step();
        le_bus_ack = 1'b0;
        chk("le_lb_wdata", le_out_wdata, 32'hFFFF_FFF2);
        step();

        // Little-endian LW misaligned
        le_in_valid = 1'b1; le_in_op = 4'd5; le_in_addr = 32'h2003;
        step();
        le_in_valid = 1'b0;
        chk("le_lw_mis_no_bus", 32'(le_bus_req), 32'd0);
        chk("le_lw_mis_exc", 32'(le_out_exc), 32'd1);
        chk("le_lw_mis_badaddr", le_out_badaddr, 32'h2003);
        chk("le_lw_mis_wreg", 32'(le_out_wreg), 32'd0);
        step();

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Multi-cycle load/store unit that replaces the purely combinational memory stage.
- Accepts one memory operation at a time from the EX/MEM boundary over a valid/ready handshake.
- Drives a variable-latency data bus with request/acknowledge/error signalling and produces a registered writeback result.
- Adds features the combinational stage lacks: alignment exceptions, bus error/timeout reporting, LL/SC link tracking and pipeline flush handling.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, maximum cycles waiting for bus_ack before a bus-timeout exception; 0 disables the timeout.
- BIG_ENDIAN, 1, lane order. 1: address offset 0 maps to bits [31:24] / sel 4'b1000. 0: offset 0 maps to bits [7:0] / sel 4'b0001.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  operation present
- in_ready  out  1  unit can accept an operation (state IDLE)
- in_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC, others NONE
- in_addr  in  ADDR_W  effective address
- in_sdata  in  32  store data (rt)
- in_wd  in  5  destination register
- in_wreg  in  1  destination write enable
- in_wdata  in  32  EX result, passed through for NONE
- flush  in  1  pipeline flush: suppress pending result, clear link
- out_valid  out  1  one-cycle result strobe
- out_wd  out  5  destination register
- out_wreg  out  1  write enable (forced 0 on any exception)
- out_wdata  out  32  load / SC / pass-through result
- out_exc  out  2  0 none, 1 load/LL misaligned, 2 store/SC misaligned, 3 bus error/timeout
- out_badaddr  out  ADDR_W  faulting address (valid when out_exc != 0)
- bus_req  out  1  bus request
- bus_we  out  1  write
- bus_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2], 2'b00}
- bus_sel  out  4  byte lane enables
- bus_wdata  out  32  store data, replicated across lanes
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  transfer complete
- bus_err  in  1  transfer failed (takes precedence over bus_ack)

Behaviour:
- Reset: rst is synchronous, active-high. On reset: state IDLE; all outputs 0 except in_ready=1; link_valid=0; link_addr=0; timeout counter 0.
- Reset mid-transaction: bus_req is 0 in the cycle after rst is sampled; no result is emitted.
- FSM states: IDLE, BUS, RESP.
- IDLE: accept when in_valid & in_ready; operation fields are registered at acceptance.
  - NONE: go to RESP; out_wdata = in_wdata.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW/LL/SC with addr[1:0]!=0): go to RESP with out_exc 1 or 2 and out_badaddr = addr. No bus activity.
  - SC with link_valid=0 or link_addr != addr[ADDR_W-1:2]: go to RESP with out_wdata=0. No bus activity; link cleared.
  - Otherwise go to BUS.
- BUS: bus_req=1. bus_addr, bus_we, bus_sel and bus_wdata stay constant until completion.
  - bus_err, or timeout counter reaching TIMEOUT: go to RESP with out_exc=3 and out_badaddr = addr.
  - bus_ack: capture the lane-extracted result, go to RESP.
  - bus_req is deasserted in the cycle after ack/err/timeout.
- RESP: out_valid=1 for exactly one cycle, then IDLE. in_ready=0 in BUS and RESP.
- Latency: NONE, misaligned or failed SC → out_valid 1 cycle after acceptance. Bus ops → out_valid 1 cycle after the ack cycle; minimum 2 cycles when ack arrives in the first BUS cycle.
- Lane rules (shown for BIG_ENDIAN=1; lanes mirror when BIG_ENDIAN=0):
  - LB/LBU: sel one-hot per addr[1:0]; byte sign-extended or zero-extended.
  - LH/LHU: addr[1]=0 → sel 1100, upper half; addr[1]=1 → sel 0011, lower half.
  - LW/LL: sel 1111.
  - SB: data {4{b}}. SH: data {2{h}}. SW/SC: data as-is.
- LL/SC:
  - Successful LL sets link_valid=1, link_addr = addr word.
  - Successful SC returns out_wdata=1 and clears link.
  - SC with bus error returns exc 3 and clears link.
  - Any completed store (SB/SH/SW) to the linked word clears link.
- flush:
  - Flush in IDLE or RESP: no out_valid that cycle, state goes to IDLE, link cleared.
  - Flush in BUS: the bus transfer still completes (bus_req held), but out_valid is suppressed; link cleared.
  - Flush and in_valid in the same cycle: the op is not accepted.
- out_wdata, out_wd, out_wreg and out_exc are held stable during RESP. They are don't-care otherwise (implemented as last value).

Test Plan:
- LB at addr 0x1001, bus_rdata 0x12_F3_56_78, ack in 3rd BUS cycle:
  - bus_sel=0100, bus_addr=0x1000.
  - out_wdata=0xFFFFFFF3, out_valid exactly 1 cycle after ack.
- LHU at addr 0x2002 with BIG_ENDIAN=0, rdata 0x8001_1234 → sel 1100, out_wdata=0x00008001.
- SH at addr 0x3001 → no bus_req, out_exc=2, out_badaddr=0x3001, out_wreg=0, out_valid 1 cycle after accept.
- LL 0x4000, SC 0x4000 data 0xDEADBEEF → bus write sel 1111, SC result 1. A second SC to 0x4000 → no bus, result 0.
- LW with no ack, TIMEOUT=8 → bus_req high 8 cycles, then out_exc=3, and bus_req=0 the next cycle.
- SW with flush asserted in the 2nd BUS cycle, ack in the 4th → bus_req held until ack, no out_valid. rst asserted during BUS of the next op → bus_req=0 the following cycle, in_ready=1.
